// File: rtl/song_sequencer_pkg.sv
// Shared types and default sizing for the song sequencer.
// State encoding and width defaults are used by the interface, top and beat counter.
package song_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  localparam int DEF_ADDR_W      = 5;
  localparam int DEF_SONG_LEN    = 32;
  localparam int DEF_PER_W       = 16;
  localparam int DEF_DUR_W       = 4;
  localparam int DEF_BEAT_CYCLES = 1000;

endpackage

// File: rtl/song_sequencer_if.sv
// Signal bundle between the sequencer, the play/pause FSM, the song memory and the speaker stage.
// The master side is the sequencer itself.
interface song_sequencer_if
  import song_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PER_W  = DEF_PER_W,
  parameter int DUR_W  = DEF_DUR_W
);

  logic              play;
  logic [PER_W-1:0]  note_period;
  logic [DUR_W-1:0]  note_dur;
  logic [ADDR_W-1:0] addr;
  logic              tone;
  logic              playing;
  logic              song_end;

  modport master (
    input  play, note_period, note_dur,
    output addr, tone, playing, song_end
  );

  modport slave (
    output play, note_period, note_dur,
    input  addr, tone, playing, song_end
  );

endinterface

// File: rtl/song_sequencer_beat_tick_gen.sv
// Enable-gated, clearable beat counter: one tick every BEAT_CYCLES enabled cycles.
// The tick is qualified by enable so a frozen counter never fires.
module song_sequencer_beat_tick_gen
  import song_sequencer_pkg::*;
#(
  parameter int BEAT_CYCLES = DEF_BEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEAT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Beat position counter, held while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      if (cnt_r == LAST_CNT) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = enable && (cnt_r == LAST_CNT);

endmodule

// File: rtl/song_sequencer.sv
// Steps through the song memory while play is high, producing a square-wave tone per note.
// Pausing freezes position inside the current note; the song loops forever.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SONG_LEN    = DEF_SONG_LEN,
  parameter int PER_W       = DEF_PER_W,
  parameter int DUR_W       = DEF_DUR_W,
  parameter int BEAT_CYCLES = DEF_BEAT_CYCLES
) (
  input logic              clk,
  input logic              reset,
  song_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  state_e            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic              tone_r;
  logic              playing_r;
  logic              song_end_r;
  logic [PER_W-1:0]  period_r;
  logic [PER_W-1:0]  tone_cnt_r;
  logic [DUR_W-1:0]  beats_left_r;

  logic              tick_s;
  logic              beat_en_s;
  logic              beat_clr_s;
  logic              toggle_s;
  logic              note_end_s;
  logic [DUR_W-1:0]  fetch_beats_s;

  song_sequencer_beat_tick_gen #(
    .BEAT_CYCLES (BEAT_CYCLES)
  ) u_beat (
    .clk    (clk),
    .reset  (reset),
    .clear  (beat_clr_s),
    .enable (beat_en_s),
    .tick   (tick_s)
  );

  // Per-cycle decode of beat, tone and note-end events.
  always_comb begin
    beat_en_s  = (state_r == ST_PLAY);
    beat_clr_s = (state_r == ST_FETCH);
    toggle_s   = (period_r != '0) && (tone_cnt_r == (period_r - PER_W'(1'b1)));
    note_end_s = beat_en_s && tick_s && (beats_left_r == DUR_W'(1'b1));
    if (bus.note_dur == '0) begin
      fetch_beats_s = DUR_W'(1'b1);
    end else begin
      fetch_beats_s = bus.note_dur;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      tone_r       <= 1'b0;
      playing_r    <= 1'b0;
      song_end_r   <= 1'b0;
      period_r     <= '0;
      tone_cnt_r   <= '0;
      beats_left_r <= '0;
    end else begin
      song_end_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tone_r    <= 1'b0;
          playing_r <= 1'b0;
          state_r   <= bus.play ? ST_FETCH : ST_IDLE;
        end
        ST_FETCH: begin
          period_r     <= bus.note_period;
          beats_left_r <= fetch_beats_s;
          tone_cnt_r   <= '0;
          tone_r       <= 1'b0;
          playing_r    <= bus.play;
          state_r      <= bus.play ? ST_PLAY : ST_PAUSE;
        end
        ST_PLAY: begin
          if ((period_r == '0) || toggle_s) begin
            tone_cnt_r <= '0;
          end else begin
            tone_cnt_r <= tone_cnt_r + PER_W'(1'b1);
          end
          if (tick_s && !note_end_s) begin
            beats_left_r <= beats_left_r - DUR_W'(1'b1);
          end else begin
            beats_left_r <= beats_left_r;
          end
          // Note end wins over a simultaneous pause; FETCH then routes to PAUSE.
          if (note_end_s) begin
            if (addr_r == LAST_ADDR) begin
              addr_r     <= '0;
              song_end_r <= 1'b1;
            end else begin
              addr_r     <= addr_r + ADDR_W'(1'b1);
            end
            tone_r    <= 1'b0;
            playing_r <= 1'b0;
            state_r   <= ST_FETCH;
          end else if (!bus.play) begin
            tone_r    <= 1'b0;
            playing_r <= 1'b0;
            state_r   <= ST_PAUSE;
          end else begin
            tone_r    <= tone_r ^ toggle_s;
            playing_r <= 1'b1;
            state_r   <= ST_PLAY;
          end
        end
        ST_PAUSE: begin
          tone_r    <= 1'b0;
          playing_r <= bus.play;
          state_r   <= bus.play ? ST_PLAY : ST_PAUSE;
        end
        default: begin
          tone_r    <= 1'b0;
          playing_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.addr     = addr_r;
  assign bus.tone     = tone_r;
  assign bus.playing  = playing_r;
  assign bus.song_end = song_end_r;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a 4-note song and 4-cycle beats.
// Each step advances one clock and checks the registered outputs 1 time unit later.
module tb_song_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  song_sequencer_if #(.ADDR_W(5), .PER_W(16), .DUR_W(4)) bus ();

  song_sequencer #(
    .ADDR_W      (5),
    .SONG_LEN    (4),
    .PER_W       (16),
    .DUR_W       (4),
    .BEAT_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Asynchronous-read song memory: {3,2},{0,1},{2,0},{1,1}.
  always_comb begin
    case (bus.addr)
      5'd0:    begin bus.note_period = 16'd3; bus.note_dur = 4'd2; end
      5'd1:    begin bus.note_period = 16'd0; bus.note_dur = 4'd1; end
      5'd2:    begin bus.note_period = 16'd2; bus.note_dur = 4'd0; end
      5'd3:    begin bus.note_period = 16'd1; bus.note_dur = 4'd1; end
      default: begin bus.note_period = 16'd0; bus.note_dur = 4'd0; end
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int a, input bit t, input bit p, input bit se);
    chk1({tag, ".addr"},     32'(bus.addr),     32'(a));
    chk1({tag, ".tone"},     32'(bus.tone),     32'(t));
    chk1({tag, ".playing"},  32'(bus.playing),  32'(p));
    chk1({tag, ".song_end"}, 32'(bus.song_end), 32'(se));
  endtask

  task automatic cyc(input string tag, input int a, input bit t, input bit p, input bit se);
    step();
    chk_all(tag, a, t, p, se);
  endtask

  // Note 0 (half-period 3), PLAY edges 1..7 after its first PLAY cycle was observed.
  task automatic note0_first7(input string tag);
    cyc({tag, ".e1"}, 0, 1'b0, 1'b1, 1'b0);
    cyc({tag, ".e2"}, 0, 1'b0, 1'b1, 1'b0);
    cyc({tag, ".e3"}, 0, 1'b1, 1'b1, 1'b0);
    cyc({tag, ".e4"}, 0, 1'b1, 1'b1, 1'b0);
    cyc({tag, ".e5"}, 0, 1'b1, 1'b1, 1'b0);
    cyc({tag, ".e6"}, 0, 1'b0, 1'b1, 1'b0);
    cyc({tag, ".e7"}, 0, 1'b0, 1'b1, 1'b0);
  endtask

  // From the FETCH of note 1 through the wrap back into note 0's first PLAY cycle.
  task automatic notes_1_to_3();
    cyc("n1.start", 1, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc("n1.rest", 1, 1'b0, 1'b1, 1'b0);
    cyc("n1.end",   2, 1'b0, 1'b0, 1'b0);
    cyc("n2.start", 2, 1'b0, 1'b1, 1'b0);
    cyc("n2.e1",    2, 1'b0, 1'b1, 1'b0);
    cyc("n2.e2",    2, 1'b1, 1'b1, 1'b0);
    cyc("n2.e3",    2, 1'b1, 1'b1, 1'b0);
    cyc("n2.end",   3, 1'b0, 1'b0, 1'b0);
    cyc("n3.start", 3, 1'b0, 1'b1, 1'b0);
    cyc("n3.e1",    3, 1'b1, 1'b1, 1'b0);
    cyc("n3.e2",    3, 1'b0, 1'b1, 1'b0);
    cyc("n3.e3",    3, 1'b1, 1'b1, 1'b0);
    cyc("n3.end",   0, 1'b0, 1'b0, 1'b1);
    cyc("wrap.n0",  0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    bus.play = 1'b1;
    repeat (3) step();
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Start-up latency and the first full pass through the song.
    cyc("fetch0",   0, 1'b0, 1'b0, 1'b0);
    cyc("n0.start", 0, 1'b0, 1'b1, 1'b0);
    note0_first7("n0");
    cyc("n0.end",   1, 1'b0, 1'b0, 1'b0);
    notes_1_to_3();

    // Pause during note 0's third PLAY cycle, then resume the remaining 5 cycles.
    cyc("p.e1", 0, 1'b0, 1'b1, 1'b0);
    cyc("p.e2", 0, 1'b0, 1'b1, 1'b0);
    bus.play = 1'b0;
    cyc("p.enter", 0, 1'b0, 1'b0, 1'b0);
    repeat (10) cyc("p.hold", 0, 1'b0, 1'b0, 1'b0);
    bus.play = 1'b1;
    cyc("p.resume", 0, 1'b0, 1'b1, 1'b0);
    cyc("p.e4",     0, 1'b0, 1'b1, 1'b0);
    cyc("p.e5",     0, 1'b0, 1'b1, 1'b0);
    cyc("p.e6",     0, 1'b1, 1'b1, 1'b0);
    cyc("p.e7",     0, 1'b1, 1'b1, 1'b0);
    cyc("p.end",    1, 1'b0, 1'b0, 1'b0);
    notes_1_to_3();

    // play falls on note 0's final cycle: the note still ends, then FETCH goes to PAUSE.
    note0_first7("d");
    bus.play = 1'b0;
    cyc("d.end",        1, 1'b0, 1'b0, 1'b0);
    cyc("d.fetchpause", 1, 1'b0, 1'b0, 1'b0);
    cyc("d.hold",       1, 1'b0, 1'b0, 1'b0);
    bus.play = 1'b1;
    cyc("d.resume", 1, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc("d.n1", 1, 1'b0, 1'b1, 1'b0);
    cyc("d.n1end",  2, 1'b0, 1'b0, 1'b0);
    cyc("d.n2",     2, 1'b0, 1'b1, 1'b0);

    // Reset mid-note, then IDLE waits for play.
    reset = 1'b1;
    step();
    chk_all("midreset", 0, 1'b0, 1'b0, 1'b0);
    reset    = 1'b0;
    bus.play = 1'b0;
    repeat (2) cyc("idle", 0, 1'b0, 1'b0, 1'b0);
    bus.play = 1'b1;
    cyc("idle.fetch", 0, 1'b0, 1'b0, 1'b0);
    cyc("idle.play",  0, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
